// File: rtl/uart_baud_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_ctrl_if
// Purpose  : Register bus between a host and the UART baud-control block.
//            A write or read is a single-cycle strobe; read data comes back
//            registered one cycle after the read strobe.
// Signals  : addr  [2:0]  register address
//            wdata [7:0]  write data
//            wr_en        write strobe
//            rd_en        read strobe
//            rdata [7:0]  registered read data (driven by the slave)
// Modports : master (host side), slave (uart_baud_ctrl side)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_baud_ctrl_if;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] rdata;

    modport master (output addr, output wdata, output wr_en, output rd_en, input  rdata);
    modport slave  (input  addr, input  wdata, input  wr_en, input  rd_en, output rdata);
endinterface
`default_nettype wire

// File: rtl/uart_baud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_ctrl
// Purpose  : Holds a shadow baud divisor and line-control register, and
//            commits the divisor to the baud generator with a safe apply
//            sequence: wait for the transmitter to go idle, present the
//            divisor with the latch strobe (LCR[7]) high for two cycles,
//            drop the strobe, then wait for the first baud tick.
// Ports    : clk       system clock, rising edge
//            reset     synchronous, active-low reset
//            bus       register bus (uart_baud_ctrl_if.slave)
//            tx_busy   datapath mid-frame; divisor must not change
//            bclk      baud tick from the generator
//            DLR       committed divisor
//            LCR       line control; bit 7 is the divisor-latch strobe
//            cfg_busy  apply sequence in progress
//            cfg_done  one-cycle pulse when an apply sequence completes
// Registers: 0 DLL (RW), 1 DLM (RW), 3 LCR (RW, bit 7 read-only strobe),
//            5 STATUS (RO: bit0 busy, bit1 locked, bit2 err), 7 CMD (WO)
// Options  : TICK_TIMEOUT_EN - when defined, WAIT_TICK gives up after
//            DLR+4 cycles without a tick and flags err.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    uart_baud_ctrl_if.slave        bus,
    input  logic                   tx_busy,
    input  logic                   bclk,
    output logic [15:0]            DLR,
    output logic [7:0]             LCR,
    output logic                   cfg_busy,
    output logic                   cfg_done
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WAIT_IDLE = 3'd1;
    localparam logic [2:0] c_LATCH     = 3'd2;
    localparam logic [2:0] c_RELEASE   = 3'd3;
    localparam logic [2:0] c_WAIT_TICK = 3'd4;

    localparam logic [2:0] c_ADDR_DLL    = 3'd0;
    localparam logic [2:0] c_ADDR_DLM    = 3'd1;
    localparam logic [2:0] c_ADDR_LCR    = 3'd3;
    localparam logic [2:0] c_ADDR_STATUS = 3'd5;
    localparam logic [2:0] c_ADDR_CMD    = 3'd7;

    logic [2:0]  r_state;
    logic [15:0] r_shadow;
    logic [15:0] r_dlr;
    logic [6:0]  r_lcr_lo;
    logic [7:0]  r_rdata;
    logic        r_busy;
    logic        r_done;
    logic        r_locked;
    logic        r_err;
    logic        r_latch_cnt;

    logic        w_apply;
    logic        w_strobe;
    logic [7:0]  w_lcr;
    logic [7:0]  w_status;
    logic [7:0]  w_rd_mux;
    logic        w_timeout;

    assign w_apply  = bus.wr_en && (bus.addr == c_ADDR_CMD) && bus.wdata[0];
    // The strobe is a pure decode of the state register, so it drops on the
    // very cycle reset returns the FSM to IDLE.
    assign w_strobe = (r_state == c_LATCH);
    assign w_lcr    = {w_strobe, r_lcr_lo};
    assign w_status = {5'b00000, r_err, r_locked, r_busy};

`ifdef TICK_TIMEOUT_EN
    logic [16:0] r_tick_cnt;
    logic [16:0] w_tick_cnt_nxt;

    // r_tick_cnt counts completed WAIT_TICK cycles; the timeout fires on the
    // cycle whose completion makes that count equal DLR+4. 17 bits hold
    // 16'hFFFF + 4 without wrapping.
    assign w_tick_cnt_nxt = r_tick_cnt + 17'd1;
    assign w_timeout      = (w_tick_cnt_nxt == ({1'b0, r_dlr} + 17'd4));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick_cnt <= 17'd0;
        end else if (r_state != c_WAIT_TICK) begin
            r_tick_cnt <= 17'd0;
        end else begin
            r_tick_cnt <= w_tick_cnt_nxt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Apply sequencer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_dlr       <= 16'h0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_latch_cnt <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_apply) begin
                        r_state  <= c_WAIT_IDLE;
                        r_busy   <= 1'b1;
                        r_locked <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                c_WAIT_IDLE: begin
                    // The divisor is loaded on the edge that enters LATCH so
                    // it is already valid on the first strobe cycle.
                    if (!tx_busy) begin
                        r_state     <= c_LATCH;
                        r_dlr       <= r_shadow;
                        r_latch_cnt <= 1'b0;
                    end
                end
                c_LATCH: begin
                    if (r_latch_cnt) begin
                        r_state <= c_RELEASE;
                    end else begin
                        r_latch_cnt <= 1'b1;
                    end
                end
                c_RELEASE: begin
                    r_state <= c_WAIT_TICK;
                end
                c_WAIT_TICK: begin
                    if (bclk) begin
                        r_state  <= c_IDLE;
                        r_done   <= 1'b1;
                        r_locked <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= c_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Register-file writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shadow <= 16'h0000;
            r_lcr_lo <= 7'h00;
        end else if (bus.wr_en) begin
            case (bus.addr)
                c_ADDR_DLL: r_shadow[7:0]  <= bus.wdata;
                c_ADDR_DLM: r_shadow[15:8] <= bus.wdata;
                c_ADDR_LCR: r_lcr_lo       <= bus.wdata[6:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (bus.addr)
            c_ADDR_DLL:    w_rd_mux = r_shadow[7:0];
            c_ADDR_DLM:    w_rd_mux = r_shadow[15:8];
            c_ADDR_LCR:    w_rd_mux = w_lcr;
            c_ADDR_STATUS: w_rd_mux = w_status;
            default:       w_rd_mux = 8'h00;
        endcase
    end

    // Read data samples the current register values, so a coincident write
    // to the same address returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= 8'h00;
        end else if (bus.rd_en) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign bus.rdata = r_rdata;
    assign DLR       = r_dlr;
    assign LCR       = w_lcr;
    assign cfg_busy  = r_busy;
    assign cfg_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_baud_ctrl
// Purpose  : Directed self-checking bench for uart_baud_ctrl. Inputs change
//            1 time unit after a rising edge; outputs are sampled at the same
//            point, well away from the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_baud_ctrl;

    logic        clk;
    logic        reset;
    logic        tx_busy;
    logic        bclk;
    logic [15:0] DLR;
    logic [7:0]  LCR;
    logic        cfg_busy;
    logic        cfg_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    uart_baud_ctrl_if bus ();

    uart_baud_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx_busy  (tx_busy),
        .bclk     (bclk),
        .DLR      (DLR),
        .LCR      (LCR),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input string tag, input logic [7:0] exp);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk(tag, {24'h0, bus.rdata}, {24'h0, exp});
    endtask

    initial begin
        reset     = 1'b0;
        tx_busy   = 1'b0;
        bclk      = 1'b0;
        bus.addr  = 3'd0;
        bus.wdata = 8'h00;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst_dlr",   {16'h0, DLR}, 32'h0000);
        chk("rst_lcr",   {24'h0, LCR}, 32'h00);
        chk("rst_busy",  {31'h0, cfg_busy}, 32'h0);
        chk("rst_done",  {31'h0, cfg_done}, 32'h0);
        chk("rst_rdata", {24'h0, bus.rdata}, 32'h00);
        reset = 1'b1;
        step();

        // ---------------- basic apply, divisor 0x000A ----------------
        bus_write(3'd0, 8'h0A);
        bus_write(3'd1, 8'h00);
        bus_write(3'd7, 8'h01);                       // now WAIT_IDLE
        chk("t1_busy_set", {31'h0, cfg_busy}, 32'h1);
        chk("t1_lcr_idle", {24'h0, LCR}, 32'h00);
        step();                                       // LATCH cycle 1
        chk("t1_latch1_lcr", {24'h0, LCR}, 32'h80);
        chk("t1_latch1_dlr", {16'h0, DLR}, 32'h000A);
        step();                                       // LATCH cycle 2
        chk("t1_latch2_lcr", {24'h0, LCR}, 32'h80);
        chk("t1_latch2_dlr", {16'h0, DLR}, 32'h000A);
        step();                                       // RELEASE
        chk("t1_release_lcr", {24'h0, LCR}, 32'h00);
        chk("t1_release_busy", {31'h0, cfg_busy}, 32'h1);
        step();                                       // WAIT_TICK
        chk("t1_wtick_busy", {31'h0, cfg_busy}, 32'h1);
        chk("t1_wtick_done", {31'h0, cfg_done}, 32'h0);
        bclk = 1'b1;
        step();
        bclk = 1'b0;
        chk("t1_done_pulse", {31'h0, cfg_done}, 32'h1);
        chk("t1_busy_clr",   {31'h0, cfg_busy}, 32'h0);
        step();
        chk("t1_done_once",  {31'h0, cfg_done}, 32'h0);
        bus_read(3'd5, "t1_status", 8'h02);

        // ---------------- apply held off by tx_busy ----------------
        tx_busy = 1'b1;
        bus_write(3'd0, 8'h20);
        repeat (20) step();
        bus_write(3'd7, 8'h01);                       // WAIT_IDLE
        bclk = 1'b1;                                  // ticks outside WAIT_TICK are ignored
        repeat (5) step();
        chk("t2_hold_dlr",  {16'h0, DLR}, 32'h000A);
        chk("t2_hold_lcr",  {24'h0, LCR}, 32'h00);
        chk("t2_hold_busy", {31'h0, cfg_busy}, 32'h1);
        chk("t2_hold_done", {31'h0, cfg_done}, 32'h0);
        tx_busy = 1'b0;
        step();                                       // LATCH cycle 1
        chk("t2_latch_lcr", {24'h0, LCR}, 32'h80);
        chk("t2_latch_dlr", {16'h0, DLR}, 32'h0020);
        step();                                       // LATCH cycle 2
        step();                                       // RELEASE
        chk("t2_release_lcr", {24'h0, LCR}, 32'h00);
        step();                                       // WAIT_TICK
        bclk = 1'b0;
        chk("t2_wtick_done", {31'h0, cfg_done}, 32'h0);

        // ---------------- CMD and DLL writes during WAIT_TICK ----------------
        step();
        chk("t3_still_busy", {31'h0, cfg_busy}, 32'h1);
        bus_write(3'd7, 8'h01);
        bus_write(3'd0, 8'h55);
        bclk = 1'b1;
        step();
        bclk = 1'b0;
        if (cfg_done) n_done++;
        repeat (4) begin
            step();
            if (cfg_done) n_done++;
        end
        chk("t3_done_count", n_done, 32'd1);
        chk("t3_dlr_kept",   {16'h0, DLR}, 32'h0020);
        chk("t3_no_queue",   {31'h0, cfg_busy}, 32'h0);
        bus_read(3'd0, "t3_dll_read", 8'h55);

        // ---------------- LCR, unmapped, CMD reads ----------------
        bus_write(3'd3, 8'hFF);
        chk("t4_lcr_out", {24'h0, LCR}, 32'h7F);
        bus_read(3'd3, "t4_lcr_read", 8'h7F);
        bus_read(3'd7, "t4_cmd_read", 8'h00);
        bus_read(3'd2, "t4_unmapped_read", 8'h00);
        bus_read(3'd1, "t4_dlm_read", 8'h00);

        // simultaneous read and write of the same register
        bus.addr  = 3'd0;
        bus.wdata = 8'h77;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("t4_rw_prewrite", {24'h0, bus.rdata}, 32'h55);
        bus_read(3'd0, "t4_rw_postwrite", 8'h77);

        // ---------------- reset during LATCH ----------------
        bus_write(3'd7, 8'h01);                       // WAIT_IDLE
        step();                                       // LATCH
        chk("t5_in_latch_lcr", {24'h0, LCR}, 32'hFF);
        reset = 1'b0;
        step();
        chk("t5_rst_dlr",   {16'h0, DLR}, 32'h0000);
        chk("t5_rst_lcr",   {24'h0, LCR}, 32'h00);
        chk("t5_rst_busy",  {31'h0, cfg_busy}, 32'h0);
        chk("t5_rst_done",  {31'h0, cfg_done}, 32'h0);
        chk("t5_rst_rdata", {24'h0, bus.rdata}, 32'h00);
        reset = 1'b1;
        step();
        chk("t5_post_done", {31'h0, cfg_done}, 32'h0);
        chk("t5_post_lcr",  {24'h0, LCR}, 32'h00);
        bus_read(3'd5, "t5_status", 8'h00);
        bus_read(3'd0, "t5_shadow", 8'h00);

        // ---------------- tick wait with divisor 3, no bclk ----------------
        bus_write(3'd0, 8'h03);
        bus_write(3'd1, 8'h00);
        bus_write(3'd7, 8'h01);                       // WAIT_IDLE
        repeat (4) step();                            // LATCH, LATCH, RELEASE, WAIT_TICK
        chk("t6_dlr", {16'h0, DLR}, 32'h0003);
        repeat (6) step();                            // six WAIT_TICK cycles done
        chk("t6_busy_before", {31'h0, cfg_busy}, 32'h1);
        step();                                       // seventh cycle done
`ifdef TICK_TIMEOUT_EN
        chk("t6_timeout_busy", {31'h0, cfg_busy}, 32'h0);
        chk("t6_timeout_done", {31'h0, cfg_done}, 32'h0);
        bus_read(3'd5, "t6_status_err", 8'h04);
`else
        repeat (20) step();
        chk("t6_wait_busy", {31'h0, cfg_busy}, 32'h1);
        bus_read(3'd5, "t6_status_wait", 8'h01);
        bclk = 1'b1;
        step();
        bclk = 1'b0;
        chk("t6_late_done", {31'h0, cfg_done}, 32'h1);
        bus_read(3'd5, "t6_status_lock", 8'h02);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
